// File: rtl/icache_responder_pkg.sv
// rtl/icache_responder_pkg.sv - shared cpu cache types for the instruction responder
package icache_responder_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    // Widest tag any legal SETS (>=2) can need; narrower tags are zero-extended.
    localparam int ICACHE_TAG_W = 29;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        REFILL
    } icache_state_t;

    function automatic logic [ICACHE_TAG_W-1:0] tag_of(input logic [31:0] addr, input int idx_w);
        logic [31:0] shifted;
        shifted = addr >> (idx_w + 2);
        return shifted[ICACHE_TAG_W-1:0];
    endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped frame storage, one comb read port, one sync write port, flush-all
module icache_array
    import icache_responder_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic                    clk,
    input  logic                    flush,
    input  logic [IDX_W-1:0]        rd_index,
    output icache_frame_t           rd_frame,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_index,
    input  logic [ICACHE_TAG_W-1:0] wr_tag,
    input  logic [31:0]             wr_data
);

    logic [SETS-1:0]         valid;
    logic [ICACHE_TAG_W-1:0] tags [SETS];
    logic [31:0]             words [SETS];

    // Only the valid bits are cleared; tag/data contents are don't-care until refilled.
    always_ff @(posedge clk) begin
        if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            words[wr_index] <= wr_data;
        end
    end

    always_comb begin
        rd_frame       = '0;
        rd_frame.valid = valid[rd_index];
        rd_frame.tag   = tags[rd_index];
        rd_frame.data  = words[rd_index];
    end

endmodule

// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - instruction cache responder with single-outstanding refill; ICACHE_PERF_EN adds hit/miss counters
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int          SETS    = ICACHE_SETS,
    parameter logic [31:0] PC_INIT = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);

    icache_state_t state, next_state;
    logic [31:0]   miss_addr;
    icache_frame_t frame;
    logic          hit;
    logic          start_miss;
    logic          fill;
    logic          unused_pc_init;

    assign unused_pc_init = ^PC_INIT;

    assign hit  = frame.valid && (frame.tag == tag_of(imemaddr, IDX_W));
    // A completion coinciding with halt or reset is dropped.
    assign fill = (state == REFILL) && !iwait && !halt && !RST;

    icache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk      (CLK),
        .flush    (RST || halt),
        .rd_index (imemaddr[IDX_W+1:2]),
        .rd_frame (frame),
        .wr_en    (fill),
        .wr_index (miss_addr[IDX_W+1:2]),
        .wr_tag   (tag_of(miss_addr, IDX_W)),
        .wr_data  (iload)
    );

    always_comb begin
        next_state = state;
        start_miss = 1'b0;
        ihit       = 1'b0;
        case (state)
            IDLE: begin
                ihit = imemREN && hit && !halt;
                if (imemREN && !hit && !halt) begin
                    start_miss = 1'b1;
                    next_state = REFILL;
                end
            end
            REFILL: begin
                if (halt || !iwait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state <= next_state;
            if (start_miss) begin
                miss_addr <= {imemaddr[31:2], 2'b00};
            end
        end
    end

    assign iREN     = (state == REFILL);
    assign iaddr    = iREN ? miss_addr : 32'h0;
    assign imemload = ihit ? frame.data : 32'h0;

`ifdef ICACHE_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
